// File: rtl/store_issue_queue.sv
// Committed-store issue queue: a circular FIFO between commit and the write-buffer port.
// The head entry is presented combinationally and popped by a one-cycle acknowledge.
// A per-entry valid bit feeds a 16-byte-line load hazard probe.
module store_issue_queue #(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned AMSB   = 31
) (
   input  logic          clk_i,
   input  logic          rst_i,
   // push side
   input  logic          st_v_i,
   input  logic [3:0]    st_id_i,
   input  logic [3:0]    st_rid_i,
   input  logic          st_cr_i,
   input  logic [9:0]    st_sel_i,
   input  logic [AMSB:0] st_adr_i,
   input  logic [79:0]   st_dat_i,
   output logic          st_rdy_o,
   // write-buffer port
   output logic          wr_o,
   input  logic          ack_i,
   output logic [3:0]    id_o,
   output logic [3:0]    rid_o,
   output logic [9:0]    sel_o,
   output logic [AMSB:0] adr_o,
   output logic [79:0]   dat_o,
   output logic          cr_o,
   // control and status
   input  logic          flush_i,
   input  logic [AMSB:0] ld_adr_i,
   output logic          ld_hit_o,
   output logic [4:0]    count_o,
   output logic          empty_o
);

   localparam int unsigned PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [4:0]  DepthC = 5'(QDEPTH);

   // Entry storage; contents are only meaningful where the valid bit is set.
   logic [3:0]    id_q  [QDEPTH];
   logic [3:0]    rid_q [QDEPTH];
   logic          cr_q  [QDEPTH];
   logic [9:0]    sel_q [QDEPTH];
   logic [AMSB:0] adr_q [QDEPTH];
   logic [79:0]   dat_q [QDEPTH];

   logic [QDEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [4:0]        count_q, count_d;

   logic push;
   logic pop;
   logic wr_en;

   // Handshake qualifiers; readiness looks at the registered count only, so a
   // pop in the same cycle never opens room for a push into a full queue.
   always_comb begin
      st_rdy_o = (count_q < DepthC);
      push     = st_v_i & st_rdy_o;
      pop      = ack_i & (count_q != 5'd0);
      wr_en    = push & ~flush_i;
   end

   // Next-state for pointers, count and valid bits; flush beats push and pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = 5'd0;
         vld_d   = '0;
      end else begin
         if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
         end
         if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 5'd0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Entry payload write at the tail; payload needs no reset since valid bits gate it.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         id_q[tail_q]  <= st_id_i;
         rid_q[tail_q] <= st_rid_i;
         cr_q[tail_q]  <= st_cr_i;
         sel_q[tail_q] <= st_sel_i;
         adr_q[tail_q] <= st_adr_i;
         dat_q[tail_q] <= st_dat_i;
      end
   end

   // Head presentation; fields are don't-care while the queue is empty.
   always_comb begin
      wr_o  = (count_q != 5'd0);
      id_o  = id_q[head_q];
      rid_o = rid_q[head_q];
      cr_o  = cr_q[head_q];
      sel_o = sel_q[head_q];
      adr_o = adr_q[head_q];
      dat_o = dat_q[head_q];
   end

   // Load hazard probe at 16-byte line granularity, byte selects ignored.
   always_comb begin
      ld_hit_o = 1'b0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         if (vld_q[i] && (adr_q[i][AMSB:4] == ld_adr_i[AMSB:4])) begin
            ld_hit_o = 1'b1;
         end
      end
   end

   // Status straight from the registered count.
   always_comb begin
      count_o = count_q;
      empty_o = (count_q == 5'd0);
   end

endmodule

// File: tb/tb_store_issue_queue.sv
// Bench for store_issue_queue: directed scenarios with literal expectations, then a
// randomized run, all continuously compared against a queue-based reference model.
module tb_store_issue_queue;

   localparam int unsigned QD = 4;
   localparam int unsigned AM = 31;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          st_v_i = 1'b0;
   logic [3:0]    st_id_i = '0;
   logic [3:0]    st_rid_i = '0;
   logic          st_cr_i = 1'b0;
   logic [9:0]    st_sel_i = '0;
   logic [AM:0]   st_adr_i = '0;
   logic [79:0]   st_dat_i = '0;
   logic          st_rdy_o;
   logic          wr_o;
   logic          ack_i = 1'b0;
   logic [3:0]    id_o;
   logic [3:0]    rid_o;
   logic [9:0]    sel_o;
   logic [AM:0]   adr_o;
   logic [79:0]   dat_o;
   logic          cr_o;
   logic          flush_i = 1'b0;
   logic [AM:0]   ld_adr_i = '0;
   logic          ld_hit_o;
   logic [4:0]    count_o;
   logic          empty_o;

   typedef struct {
      logic [3:0]  id;
      logic [3:0]  rid;
      logic        cr;
      logic [9:0]  sel;
      logic [AM:0] adr;
      logic [79:0] dat;
   } ent_t;

   ent_t mq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   store_issue_queue #(.QDEPTH(QD), .AMSB(AM)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .st_v_i  (st_v_i),
      .st_id_i (st_id_i),
      .st_rid_i(st_rid_i),
      .st_cr_i (st_cr_i),
      .st_sel_i(st_sel_i),
      .st_adr_i(st_adr_i),
      .st_dat_i(st_dat_i),
      .st_rdy_o(st_rdy_o),
      .wr_o    (wr_o),
      .ack_i   (ack_i),
      .id_o    (id_o),
      .rid_o   (rid_o),
      .sel_o   (sel_o),
      .adr_o   (adr_o),
      .dat_o   (dat_o),
      .cr_o    (cr_o),
      .flush_i (flush_i),
      .ld_adr_i(ld_adr_i),
      .ld_hit_o(ld_hit_o),
      .count_o (count_o),
      .empty_o (empty_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: a plain FIFO of entries updated at each rising edge.
   initial begin : model
      ent_t e;
      bit   room;
      forever begin
         @(posedge clk);
         if (rst_i || flush_i) begin
            mq.delete();
         end else begin
            room = (mq.size() < QD);
            if (ack_i && mq.size() > 0) void'(mq.pop_front());
            if (st_v_i && room) begin
               e.id  = st_id_i;
               e.rid = st_rid_i;
               e.cr  = st_cr_i;
               e.sel = st_sel_i;
               e.adr = st_adr_i;
               e.dat = st_dat_i;
               mq.push_back(e);
            end
         end
      end
   end

   // Compare process: every cycle, on the falling edge.
   initial begin : compare
      logic exp_hit;
      forever begin
         @(negedge clk);
         exp_hit = 1'b0;
         foreach (mq[i]) if (mq[i].adr[AM:4] == ld_adr_i[AM:4]) exp_hit = 1'b1;
         chk("m_wr", wr_o, mq.size() != 0);
         chk("m_rdy", st_rdy_o, mq.size() < QD);
         chk("m_count", count_o, mq.size());
         chk("m_empty", empty_o, mq.size() == 0);
         chk("m_ldhit", ld_hit_o, exp_hit);
         if (mq.size() != 0) begin
            chk("m_id", id_o, mq[0].id);
            chk("m_rid", rid_o, mq[0].rid);
            chk("m_cr", cr_o, mq[0].cr);
            chk("m_sel", sel_o, mq[0].sel);
            chk("m_adr", adr_o, mq[0].adr);
            chk("m_dat", dat_o, mq[0].dat);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic [3:0] id, input logic [AM:0] adr);
      st_v_i   = 1'b1;
      st_id_i  = id;
      st_rid_i = ~id;
      st_cr_i  = id[0];
      st_sel_i = 10'h3FF ^ {6'd0, id};
      st_adr_i = adr;
      st_dat_i = {16'hBEEF, 60'd0, id};
   endtask

   // Entered just after an edge with ack_i low: downstream accepts, acks next cycle.
   task automatic drain_one(input string nm, input logic [3:0] exp_id);
      #1;
      chk(nm, id_o, exp_id);
      step();
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
   endtask

   initial begin : stim
      logic pend;
      step();
      step();
      rst_i = 1'b0;
      #1;
      chk("rst_wr", wr_o, 1'b0);
      chk("rst_rdy", st_rdy_o, 1'b1);
      chk("rst_count", count_o, 5'd0);
      chk("rst_empty", empty_o, 1'b1);
      chk("rst_ldhit", ld_hit_o, 1'b0);
      step();

      // Single store through the full handshake.
      set_push(4'd3, 32'h1008);
      st_rid_i = 4'd5;
      st_sel_i = 10'h0FF;
      st_dat_i = 80'h1234;
      st_cr_i  = 1'b0;
      step();
      st_v_i = 1'b0;
      #1;
      chk("single_wr", wr_o, 1'b1);
      chk("single_id", id_o, 4'd3);
      chk("single_adr", adr_o, 32'h1008);
      chk("single_sel", sel_o, 10'h0FF);
      chk("single_dat", dat_o, 80'h1234);
      chk("single_cnt", count_o, 5'd1);
      step();
      ack_i = 1'b1;
      #1;
      chk("single_hold", id_o, 4'd3);
      step();
      ack_i = 1'b0;
      #1;
      chk("single_done_wr", wr_o, 1'b0);
      chk("single_done_empty", empty_o, 1'b1);
      step();

      // Fill to capacity, refuse a fifth push, drain in order (pointers wrap).
      for (int k = 0; k < 4; k++) begin
         set_push(4'(k), 32'h4000 + 32'(k * 16));
         step();
      end
      set_push(4'd4, 32'h4040);
      #1;
      chk("fill_cnt", count_o, 5'd4);
      chk("fill_rdy", st_rdy_o, 1'b0);
      step();
      st_v_i = 1'b0;
      #1;
      chk("fill_drop_cnt", count_o, 5'd4);
      step();
      for (int k = 0; k < 4; k++) drain_one("fill_order", 4'(k));
      #1;
      chk("fill_drained", empty_o, 1'b1);
      step();

      // Simultaneous push and pop.
      set_push(4'd8, 32'h7000);
      step();
      set_push(4'd9, 32'h7010);
      step();
      set_push(4'd10, 32'h7020);
      ack_i = 1'b1;
      step();
      st_v_i = 1'b0;
      ack_i  = 1'b0;
      #1;
      chk("pp_cnt", count_o, 5'd2);
      chk("pp_head", id_o, 4'd9);
      step();
      set_push(4'd11, 32'h7030);
      step();
      set_push(4'd12, 32'h7040);
      step();
      set_push(4'd13, 32'h7050);
      ack_i = 1'b1;
      #1;
      chk("ppfull_rdy", st_rdy_o, 1'b0);
      step();
      st_v_i = 1'b0;
      ack_i  = 1'b0;
      #1;
      chk("ppfull_cnt", count_o, 5'd3);
      chk("ppfull_head", id_o, 4'd10);
      step();
      drain_one("pp_order", 4'd10);
      drain_one("pp_order", 4'd11);
      drain_one("pp_order", 4'd12);
      #1;
      chk("pp_empty", empty_o, 1'b1);
      step();

      // Load hazard probe.
      set_push(4'd1, 32'h2010);
      step();
      st_v_i   = 1'b0;
      ld_adr_i = 32'h201C;
      #1;
      chk("haz_hit", ld_hit_o, 1'b1);
      ld_adr_i = 32'h2020;
      #1;
      chk("haz_miss", ld_hit_o, 1'b0);
      step();
      ack_i    = 1'b1;
      ld_adr_i = 32'h201C;
      step();
      ack_i = 1'b0;
      #1;
      chk("haz_popped", ld_hit_o, 1'b0);
      step();

      // Flush with wr_o high, then a late ack.
      set_push(4'd1, 32'h5000);
      step();
      set_push(4'd2, 32'h5010);
      step();
      set_push(4'd3, 32'h5020);
      step();
      st_v_i  = 1'b0;
      flush_i = 1'b1;
      #1;
      chk("fl_pre_cnt", count_o, 5'd3);
      chk("fl_pre_wr", wr_o, 1'b1);
      step();
      flush_i = 1'b0;
      ack_i   = 1'b1;
      #1;
      chk("fl_cnt", count_o, 5'd0);
      chk("fl_wr", wr_o, 1'b0);
      step();
      ack_i = 1'b0;
      #1;
      chk("fl_lateack", count_o, 5'd0);
      step();
      set_push(4'd7, 32'h5030);
      step();
      st_v_i = 1'b0;
      #1;
      chk("fl_next_wr", wr_o, 1'b1);
      chk("fl_next_id", id_o, 4'd7);
      chk("fl_next_cnt", count_o, 5'd1);
      step();
      drain_one("fl_next_drain", 4'd7);

      // Reset during a push+ack cycle.
      set_push(4'd6, 32'h6004);
      ld_adr_i = 32'h6000;
      step();
      set_push(4'd9, 32'h6008);
      ack_i = 1'b1;
      rst_i = 1'b1;
      step();
      st_v_i = 1'b0;
      ack_i  = 1'b0;
      rst_i  = 1'b0;
      #1;
      chk("rstmid_wr", wr_o, 1'b0);
      chk("rstmid_rdy", st_rdy_o, 1'b1);
      chk("rstmid_ldhit", ld_hit_o, 1'b0);
      chk("rstmid_cnt", count_o, 5'd0);
      chk("rstmid_empty", empty_o, 1'b1);
      step();

      // Randomized traffic with a protocol-following downstream plus stray acks.
      pend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         ack_i = pend;
         if (mq.size() == 0 && ($urandom % 16) == 0) ack_i = 1'b1;
         pend = (mq.size() != 0) && !ack_i && (($urandom % ((c < 1500) ? 4 : 2)) == 0);
         st_v_i   = (($urandom % 4) != 0);
         st_id_i  = 4'($urandom);
         st_rid_i = 4'($urandom);
         st_cr_i  = 1'($urandom);
         st_sel_i = 10'($urandom);
         st_adr_i = 32'h3000 | (32'($urandom % 8) << 4) | 32'($urandom % 16);
         st_dat_i = {16'($urandom), $urandom, $urandom};
         ld_adr_i = 32'h3000 | (32'($urandom % 10) << 4) | 32'($urandom % 16);
         flush_i  = (($urandom % 50) == 0);
         rst_i    = (($urandom % 300) == 0);
         step();
      end
      st_v_i  = 1'b0;
      ack_i   = 1'b0;
      flush_i = 1'b0;
      rst_i   = 1'b0;
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
